// File: rtl/mem_word_reader_if.sv
// Bundle between the byte-wide memory/FIFO read port, the word reader and its
// downstream word consumer. The master modport is the reader itself.
interface mem_word_reader_if #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4,
    parameter int CNT_W  = 16
);
    logic                      empty;
    logic                      read;
    logic [DATA_W-1:0]         mem_data;
    logic                      mem_valid;
    logic                      big;
    logic [DATA_W*BYTES-1:0]   word_out;
    logic                      word_valid;
    logic                      word_ready;
    logic [CNT_W-1:0]          word_cnt;
    logic                      underrun_err;

    modport master (
        input  empty,
        input  mem_data,
        input  mem_valid,
        input  big,
        input  word_ready,
        output read,
        output word_out,
        output word_valid,
        output word_cnt,
        output underrun_err
    );

    modport slave (
        output empty,
        output mem_data,
        output mem_valid,
        output big,
        output word_ready,
        input  read,
        input  word_out,
        input  word_valid,
        input  word_cnt,
        input  underrun_err
    );
endinterface

// File: rtl/mem_word_reader.sv
// Pulls bytes from a byte-wide memory, packs BYTES of them into a word in the
// selected byte order and hands words downstream over valid/ready.
module mem_word_reader #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_word_reader_if.master bus
);
    localparam int WORD_W = DATA_W * BYTES;
    localparam int AW     = $clog2(BYTES + 1);
    localparam logic [AW:0]   LIMIT = (AW+1)'(BYTES);
    localparam logic [AW-1:0] FULL  = AW'(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       asm_cnt_reg, asm_cnt_next;
    logic [AW-1:0]       inflight_reg, inflight_next;
    logic [WORD_W-1:0]   asm_reg, asm_next;
    logic [WORD_W-1:0]   word_reg, word_next;
    logic                word_valid_reg, word_valid_next;
    logic [CNT_W-1:0]    word_cnt_reg, word_cnt_next;
    logic                big_lat_reg, big_lat_next;
    logic                underrun_reg, underrun_next;

    logic                rd;
    logic                capture;
    logic                stray;
    logic                transfer;
    logic                consume;
    logic                big_eff;
    logic [AW:0]         budget_used;
    logic [BYTES-1:0]    lane_hit;
    logic [BYTES-1:0]    slot_we;

    // Bytes already held plus bytes still in flight may never exceed one word,
    // so a returning byte always has a free lane regardless of read latency.
    assign budget_used = {1'b0, asm_cnt_reg} + {1'b0, inflight_reg};
    assign rd          = !reset && !bus.empty && (budget_used < LIMIT);
    assign capture     = bus.mem_valid && (inflight_reg != '0);
    assign stray       = bus.mem_valid && (inflight_reg == '0);
    assign transfer    = (state_reg == HOLD) && (!word_valid_reg || bus.word_ready);
    assign consume     = word_valid_reg && bus.word_ready;

    // Lane 0 uses the live BIG input; later lanes use the value latched with it.
    assign big_eff     = (asm_cnt_reg == '0) ? bus.big : big_lat_reg;

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign lane_hit[gi] = capture && (asm_cnt_reg == AW'(gi));
            // Slot gi holds lane gi little-endian, lane BYTES-1-gi big-endian.
            assign slot_we[gi]  = big_eff ? lane_hit[BYTES-1-gi] : lane_hit[gi];
            assign asm_next[DATA_W*gi +: DATA_W] =
                slot_we[gi] ? bus.mem_data : asm_reg[DATA_W*gi +: DATA_W];
        end
    endgenerate

    always_comb begin
        inflight_next   = inflight_reg;
        asm_cnt_next    = asm_cnt_reg;
        big_lat_next    = big_lat_reg;
        underrun_next   = underrun_reg | stray;
        word_next       = word_reg;
        word_valid_next = word_valid_reg;
        word_cnt_next   = word_cnt_reg;

        case ({rd, capture})
            2'b10:   inflight_next = inflight_reg + AW'(1);
            2'b01:   inflight_next = inflight_reg - AW'(1);
            default: inflight_next = inflight_reg;
        endcase

        if (capture) begin
            asm_cnt_next = asm_cnt_reg + AW'(1);
            if (asm_cnt_reg == '0) begin
                big_lat_next = bus.big;
            end
        end

        if (consume) begin
            word_cnt_next   = word_cnt_reg + CNT_W'(1);
            word_valid_next = 1'b0;
        end

        // A reload in the same cycle as a consume keeps valid high.
        if (transfer) begin
            word_next       = asm_reg;
            word_valid_next = 1'b1;
            asm_cnt_next    = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (asm_cnt_next != '0 || inflight_next != '0) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (asm_cnt_next == FULL) begin
                    state_next = HOLD;
                end else if (asm_cnt_next == '0 && inflight_next == '0) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_next = (inflight_next != '0) ? FILL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            asm_cnt_reg    <= '0;
            inflight_reg   <= '0;
            asm_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            word_cnt_reg   <= '0;
            big_lat_reg    <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            asm_cnt_reg    <= asm_cnt_next;
            inflight_reg   <= inflight_next;
            asm_reg        <= asm_next;
            word_reg       <= word_next;
            word_valid_reg <= word_valid_next;
            word_cnt_reg   <= word_cnt_next;
            big_lat_reg    <= big_lat_next;
            underrun_reg   <= underrun_next;
        end
    end

    assign bus.read         = rd;
    assign bus.word_out     = word_reg;
    assign bus.word_valid   = word_valid_reg;
    assign bus.word_cnt     = word_cnt_reg;
    assign bus.underrun_err = underrun_reg;
endmodule

// File: tb/tb_mem_word_reader.sv
// Directed bench for mem_word_reader with a latency-1 byte memory model driven
// from the stimulus process; words are collected as they are handed off.
module tb_mem_word_reader;
    logic clk;
    logic reset;

    mem_word_reader_if #(.DATA_W(8), .BYTES(4), .CNT_W(16)) ifc ();

    mem_word_reader #(.DATA_W(8), .BYTES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  q[$];
    logic [31:0] got[$];
    logic        force_empty = 1'b0;
    logic        stray_req   = 1'b0;
    logic        s_read      = 1'b0;
    int          rd_count, viol, valid_cycles, stab_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_word(input int i);
        if (i < got.size()) return got[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic drive_empty();
        ifc.empty = (q.size() == 0) || force_empty;
    endtask

    task automatic clear_mon();
        rd_count     = 0;
        viol         = 0;
        valid_cycles = 0;
        got.delete();
    endtask

    // Inputs only change just after the rising edge, so the negedge sample is
    // exactly what the DUT sees on the next edge.
    task automatic tick();
        @(negedge clk);
        s_read = ifc.read;
        if (ifc.read) rd_count++;
        if (ifc.read && ifc.empty) viol++;
        if (ifc.word_valid) valid_cycles++;
        if (ifc.word_valid && ifc.word_ready) begin
            got.push_back(ifc.word_out);
            $display("xfer word=%h cnt_before=%0d", ifc.word_out, ifc.word_cnt);
        end
        @(posedge clk);
        #1;
        if (s_read && q.size() > 0) begin
            ifc.mem_valid = 1'b1;
            ifc.mem_data  = q.pop_front();
        end else if (stray_req) begin
            ifc.mem_valid = 1'b1;
            ifc.mem_data  = 8'h5A;
            stray_req     = 1'b0;
        end else begin
            ifc.mem_valid = 1'b0;
            ifc.mem_data  = 8'h00;
        end
        drive_empty();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        q.push_back(b0);
        q.push_back(b1);
        q.push_back(b2);
        q.push_back(b3);
        drive_empty();
    endtask

    initial begin
        reset          = 1'b1;
        ifc.empty      = 1'b1;
        ifc.mem_data   = 8'h00;
        ifc.mem_valid  = 1'b0;
        ifc.big        = 1'b1;
        ifc.word_ready = 1'b1;
        clear_mon();

        // Reset state, READ held low under reset even with data available
        tick();
        q.push_back(8'h77);
        drive_empty();
        #1;
        check("rst_read", 32'(ifc.read), 32'h0);
        tick();
        check("rst_word_out", ifc.word_out, 32'h0);
        check("rst_word_valid", 32'(ifc.word_valid), 32'h0);
        check("rst_word_cnt", 32'(ifc.word_cnt), 32'h0);
        check("rst_underrun", 32'(ifc.underrun_err), 32'h0);
        q.delete();
        drive_empty();
        do_reset();

        // Big-endian single word
        ifc.big = 1'b1;
        push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        ticks(12);
        check("t1_reads", 32'(rd_count), 32'd4);
        check("t1_nwords", 32'(got.size()), 32'd1);
        check("t1_word", get_word(0), 32'hAABBCCDD);
        check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        check("t1_word_cnt", 32'(ifc.word_cnt), 32'd1);
        check("t1_valid_after", 32'(ifc.word_valid), 32'h0);

        // Little-endian, BIG toggled after the second byte of the first word
        do_reset();
        ifc.big = 1'b0;
        push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        ticks(3);
        ifc.big = 1'b1;
        ticks(25);
        check("t2_nwords", 32'(got.size()), 32'd2);
        check("t2_word0_le", get_word(0), 32'hDDCCBBAA);
        check("t2_word1_be", get_word(1), 32'h11223344);
        check("t2_word_cnt", 32'(ifc.word_cnt), 32'd2);

        // Backpressure: 12 bytes with WORD_READY low
        do_reset();
        ifc.big        = 1'b1;
        ifc.word_ready = 1'b0;
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        push4(8'h05, 8'h06, 8'h07, 8'h08);
        push4(8'h09, 8'h0A, 8'h0B, 8'h0C);
        ticks(30);
        stab_err = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifc.word_out !== 32'h01020304 || ifc.word_valid !== 1'b1) stab_err++;
        end
        check("t3_hold_word", ifc.word_out, 32'h01020304);
        check("t3_hold_valid", 32'(ifc.word_valid), 32'h1);
        check("t3_hold_stable", 32'(stab_err), 32'd0);
        check("t3_reads_stop", 32'(rd_count), 32'd8);
        check("t3_read_low", 32'(ifc.read), 32'h0);
        check("t3_no_xfer", 32'(got.size()), 32'd0);
        ifc.word_ready = 1'b1;
        ticks(30);
        check("t3_nwords", 32'(got.size()), 32'd3);
        check("t3_word0", get_word(0), 32'h01020304);
        check("t3_word1", get_word(1), 32'h05060708);
        check("t3_word2", get_word(2), 32'h090A0B0C);
        check("t3_word_cnt", 32'(ifc.word_cnt), 32'd3);

        // EMPTY toggling every two cycles
        do_reset();
        push4(8'hA6, 8'h39, 8'hA8, 8'hF9);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) force_empty = ~force_empty;
            drive_empty();
            tick();
        end
        force_empty = 1'b0;
        drive_empty();
        ticks(10);
        check("t4_read_while_empty", 32'(viol), 32'd0);
        check("t4_reads", 32'(rd_count), 32'd4);
        check("t4_word", get_word(0), 32'hA639A8F9);

        // Reset mid-word discards the partial assembly
        q.push_back(8'hAA);
        q.push_back(8'hBB);
        drive_empty();
        ticks(6);
        reset = 1'b1;
        tick();
        check("t5_rst_word_out", ifc.word_out, 32'h0);
        check("t5_rst_valid", 32'(ifc.word_valid), 32'h0);
        check("t5_rst_cnt", 32'(ifc.word_cnt), 32'h0);
        check("t5_rst_underrun", 32'(ifc.underrun_err), 32'h0);
        reset = 1'b0;
        clear_mon();
        push4(8'hFF, 8'hFD, 8'hFF, 8'hF0);
        ticks(15);
        check("t5_nwords", 32'(got.size()), 32'd1);
        check("t5_word", get_word(0), 32'hFFFDFFF0);
        check("t5_word_cnt", 32'(ifc.word_cnt), 32'd1);

        // Stray byte: sticky error, assembly untouched
        do_reset();
        q.push_back(8'h12);
        q.push_back(8'h34);
        drive_empty();
        ticks(8);
        check("t6_underrun_before", 32'(ifc.underrun_err), 32'h0);
        stray_req = 1'b1;
        ticks(2);
        check("t6_underrun_set", 32'(ifc.underrun_err), 32'h1);
        ticks(3);
        check("t6_underrun_sticky", 32'(ifc.underrun_err), 32'h1);
        q.push_back(8'h56);
        q.push_back(8'h78);
        drive_empty();
        ticks(10);
        check("t6_word", get_word(0), 32'h12345678);
        check("t6_nwords", 32'(got.size()), 32'd1);
        check("t6_underrun_still", 32'(ifc.underrun_err), 32'h1);
        do_reset();
        check("t6_underrun_cleared", 32'(ifc.underrun_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
